// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with occupancy count, almost flags,
// sticky overflow/underflow errors and a synchronous flush.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    input  logic              flush,
    input  logic              err_clr,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_dout;
    logic              r_ovf;
    logic              r_udf;

    logic [AW:0]       w_count;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_set_ovf;
    logic              w_set_udf;

    // Pointers carry an extra wrap bit, so the difference is the occupancy 0..DEPTH.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign full      = (w_count == (AW+1)'(DEPTH));
    assign empty     = (w_count == '0);

    assign w_wr_acc  = wr_en & ~full  & ~flush;
    assign w_rd_acc  = rd_en & ~empty & ~flush;
    assign w_set_ovf = wr_en & full  & ~flush;
    assign w_set_udf = rd_en & empty & ~flush;

    assign almost_full  = (int'(w_count) >= AF_LEVEL);
    assign almost_empty = (int'(w_count) <= AE_LEVEL);
    assign count        = w_count;
    assign dout         = r_dout;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_set_ovf)
                r_ovf <= 1'b1;
            else if (err_clr)
                r_ovf <= 1'b0;
            if (w_set_udf)
                r_udf <= 1'b1;
            else if (err_clr)
                r_udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (16x8, 4x32, 2x16) share one
// stimulus stream; a queue model per instance is checked every cycle.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en, flush, err_clr;
    logic [31:0] din;

    wire  [7:0]  d0;
    wire  [31:0] d1;
    wire  [15:0] d2;
    wire  [4:0]  c0;
    wire  [2:0]  c1;
    wire  [1:0]  c2;
    wire  [2:0]  a_full, a_empty, a_af, a_ae, a_ov, a_ud;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u_d16 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din[7:0]), .rd_en(rd_en),
        .dout(d0), .flush(flush), .err_clr(err_clr), .full(a_full[0]),
        .empty(a_empty[0]), .almost_full(a_af[0]), .almost_empty(a_ae[0]),
        .count(c0), .overflow(a_ov[0]), .underflow(a_ud[0]));

    sync_fifo_param #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_d4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(d1), .flush(flush), .err_clr(err_clr), .full(a_full[1]),
        .empty(a_empty[1]), .almost_full(a_af[1]), .almost_empty(a_ae[1]),
        .count(c1), .overflow(a_ov[1]), .underflow(a_ud[1]));

    sync_fifo_param #(.DATA_W(16), .DEPTH(2), .AF_LEVEL(1), .AE_LEVEL(0)) u_d2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din[15:0]), .rd_en(rd_en),
        .dout(d2), .flush(flush), .err_clr(err_clr), .full(a_full[2]),
        .empty(a_empty[2]), .almost_full(a_af[2]), .almost_empty(a_ae[2]),
        .count(c2), .overflow(a_ov[2]), .underflow(a_ud[2]));

    int          a_cnt  [3];
    logic [31:0] a_dout [3];
    assign a_cnt[0]  = int'(c0);
    assign a_cnt[1]  = int'(c1);
    assign a_cnt[2]  = int'(c2);
    assign a_dout[0] = {24'h0, d0};
    assign a_dout[1] = d1;
    assign a_dout[2] = {16'h0, d2};

    // Reference model: one queue per instance.
    int          DEP [3] = '{16, 4, 2};
    int          AFL [3] = '{14, 3, 1};
    int          AEL [3] = '{2, 1, 0};
    logic [31:0] MSK [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] mq  [3][$];
    logic [31:0] m_dout [3];
    bit          m_ov [3];
    bit          m_ud [3];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_dout[k] = '0;
            m_ov[k]   = 1'b0;
            m_ud[k]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n;
            bit mfull, mempty, s_ov, s_ud;
            n      = mq[k].size();
            mfull  = (n == DEP[k]);
            mempty = (n == 0);
            s_ov   = wr_en && mfull  && !flush;
            s_ud   = rd_en && mempty && !flush;
            if (flush) mq[k].delete();
            else begin
                if (rd_en && !mempty) m_dout[k] = mq[k].pop_front();
                if (wr_en && !mfull)  mq[k].push_back(din & MSK[k]);
            end
            m_ov[k] = s_ov ? 1'b1 : (err_clr ? 1'b0 : m_ov[k]);
            m_ud[k] = s_ud ? 1'b1 : (err_clr ? 1'b0 : m_ud[k]);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = mq[k].size();
            chk($sformatf("d%0d.count", DEP[k]),    a_cnt[k],      n);
            chk($sformatf("d%0d.full", DEP[k]),     a_full[k],     n == DEP[k]);
            chk($sformatf("d%0d.empty", DEP[k]),    a_empty[k],    n == 0);
            chk($sformatf("d%0d.afull", DEP[k]),    a_af[k],       n >= AFL[k]);
            chk($sformatf("d%0d.aempty", DEP[k]),   a_ae[k],       n <= AEL[k]);
            chk($sformatf("d%0d.overflow", DEP[k]), a_ov[k],       m_ov[k]);
            chk($sformatf("d%0d.underflow", DEP[k]),a_ud[k],       m_ud[k]);
            chk($sformatf("d%0d.dout", DEP[k]),     a_dout[k],     m_dout[k]);
        end
    endtask

    // Inputs are applied at the falling edge; results checked at the next falling edge.
    task automatic drive(input bit w, input bit r, input logic [31:0] d,
                         input bit f = 1'b0, input bit c = 1'b0);
        wr_en = w; rd_en = r; din = d; flush = f; err_clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    // Async reset pulse fully between clock edges; outputs checked while reset is held.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst.count", a_cnt[0], 0);
        chk("rst.empty", a_empty[0], 1);
        chk("rst.aempty", a_ae[0], 1);
        chk("rst.dout", a_dout[0], 0);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          wr, rd, fl, clr;
        logic [7:0]  din;
        int          cnt;
        logic [7:0]  dout;
        bit          ov, ud;
    } vec_t;

    vec_t vt [14];

    initial begin
        // Simultaneous access, flush and err_clr corner cases, starting from reset.
        //         wr rd fl clr din    cnt dout   ov ud
        vt[0]  = '{1, 1, 0, 0, 8'h55, 1, 8'h00, 0, 1};
        vt[1]  = '{0, 0, 0, 1, 8'h00, 1, 8'h00, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 8'h56, 2, 8'h00, 0, 0};
        vt[3]  = '{1, 0, 0, 0, 8'h57, 3, 8'h00, 0, 0};
        vt[4]  = '{1, 0, 0, 0, 8'h58, 4, 8'h00, 0, 0};
        vt[5]  = '{1, 0, 0, 0, 8'h59, 5, 8'h00, 0, 0};
        vt[6]  = '{1, 1, 0, 0, 8'h5A, 5, 8'h55, 0, 0};
        vt[7]  = '{1, 0, 0, 0, 8'h5B, 6, 8'h55, 0, 0};
        vt[8]  = '{1, 0, 0, 0, 8'h5C, 7, 8'h55, 0, 0};
        vt[9]  = '{1, 1, 1, 0, 8'h5D, 0, 8'h55, 0, 0};
        vt[10] = '{0, 1, 0, 1, 8'h00, 0, 8'h55, 0, 1};
        vt[11] = '{0, 0, 0, 1, 8'h00, 0, 8'h55, 0, 0};
        vt[12] = '{1, 0, 0, 0, 8'h5E, 1, 8'h55, 0, 0};
        vt[13] = '{0, 1, 0, 0, 8'h00, 0, 8'h5E, 0, 0};

        reset = 1'b1; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; din = '0;
        model_reset();
        @(negedge clk);
        check_all();
        chk("init.count", a_cnt[0], 0);
        chk("init.afull", a_af[0], 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-stream, then the first write lands in entry 0.
        for (int i = 0; i < 5; i++) drive(1, 0, 32'h11 + i);
        drive(0, 1, 0);
        pulse_reset();
        drive(1, 0, 32'hA5);
        drive(0, 1, 0);
        chk("rst.first_rd", a_dout[0], 8'hA5);

        // Fill to full, overflow, read-while-full, drain in order.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i);
            if (i == 12) chk("fill.af_13", a_af[0], 0);
            if (i == 13) chk("fill.af_14", a_af[0], 1);
            if (i == 14) chk("fill.full_15", a_full[0], 0);
            if (i == 15) chk("fill.full_16", a_full[0], 1);
        end
        drive(1, 0, 32'hFF);
        chk("ovf.flag", a_ov[0], 1);
        chk("ovf.count", a_cnt[0], 16);
        drive(1, 1, 32'hEE);
        chk("fullrw.dout", a_dout[0], 8'h00);
        chk("fullrw.count", a_cnt[0], 15);
        chk("fullrw.ovf", a_ov[0], 1);
        for (int i = 1; i < 16; i++) begin
            drive(0, 1, 0);
            chk($sformatf("drain.%0d", i), a_dout[0], i);
        end
        drive(0, 0, 0, 0, 1);

        // Wrap-around with concurrent traffic.
        for (int i = 0; i < 10; i++) drive(1, 0, 32'h30 + i);
        for (int i = 0; i < 10; i++) drive(0, 1, 0);
        for (int i = 0; i < 12; i++) drive(1, mq[0].size() >= 1, 32'h1234_0020 + i);
        for (int i = 0; i < 20 && mq[0].size() > 0; i++) drive(0, 1, 0);
        chk("wrap.empty", a_empty[0], 1);
        drive(0, 0, 0, 0, 1);

        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].wr, vt[i].rd, {24'h0, vt[i].din}, vt[i].fl, vt[i].clr);
            chk($sformatf("vec%0d.count", i), a_cnt[0], vt[i].cnt);
            chk($sformatf("vec%0d.dout", i),  a_dout[0], vt[i].dout);
            chk($sformatf("vec%0d.ovf", i),   a_ov[0], vt[i].ov);
            chk($sformatf("vec%0d.udf", i),   a_ud[0], vt[i].ud);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom(),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
